// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu
//
// 8-bit (parameterisable) arithmetic/logic unit for the Simple CPU datapath.
// Computes ADD or AND of the accumulator and the operand register as a
// purely combinational result, and keeps a small clocked status register
// (carry and zero) that the control unit samples for conditional operations.
//
// Ports
//   clk      in   system clock; flag register updates on the rising edge
//   rst_n    in   asynchronous active-low reset; clears the flag register only
//   flag_en  in   1 = capture cout/zero into C_flag/Z_flag at the next edge
//   ALUSEL   in   operation select: 0 = ADD, 1 = AND
//   AC       in   [N-1:0] accumulator operand
//   AR       in   [N-1:0] second operand
//   q        out  [N-1:0] combinational result
//   cout     out  combinational carry-out of ADD (0 for AND)
//   zero     out  combinational, 1 when q == 0
//   C_flag   out  registered carry flag
//   Z_flag   out  registered zero flag
// ---------------------------------------------------------------------------
module alu #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flag_en,
  input  logic         ALUSEL,
  input  logic [N-1:0] AC,
  input  logic [N-1:0] AR,
  output logic [N-1:0] q,
  output logic         cout,
  output logic         zero,
  output logic         C_flag,
  output logic         Z_flag
);

  logic [N:0] sum_p0;
  logic       c_flag_p1;
  logic       z_flag_p1;

  // Stage p0: combinational result and flags (zero latency)
  assign sum_p0 = {1'b0, AC} + {1'b0, AR};

  always_comb begin
    q    = '0;
    cout = 1'b0;
    if (ALUSEL) begin
      q    = AC & AR;
      cout = 1'b0;
    end else begin
      q    = sum_p0[N-1:0];
      cout = sum_p0[N];
    end
  end

  assign zero = (q == '0);

  // Stage p1: status register, captured only when flag_en is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_flag_p1 <= 1'b0;
      z_flag_p1 <= 1'b0;
    end else if (flag_en) begin
      c_flag_p1 <= cout;
      z_flag_p1 <= zero;
    end
  end

  assign C_flag = c_flag_p1;
  assign Z_flag = z_flag_p1;

endmodule

// File: tb/tb_alu.sv
module tb_alu;

  logic       clk;
  logic       rst_n;
  logic       flag_en;
  logic       sel;
  logic [7:0] ac;
  logic [7:0] ar;
  logic [7:0] q;
  logic       cout;
  logic       zero;
  logic       c_flag;
  logic       z_flag;

  int pass_cnt = 0;
  int total    = 0;

  alu #(.N(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .flag_en(flag_en),
    .ALUSEL (sel),
    .AC     (ac),
    .AR     (ar),
    .q      (q),
    .cout   (cout),
    .zero   (zero),
    .C_flag (c_flag),
    .Z_flag (z_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       sel;
    logic [7:0] ac;
    logic [7:0] ar;
    logic [7:0] q;
    logic       cout;
    logic       zero;
  } vec_t;

  typedef struct {
    logic c;
    logic z;
  } flag_t;

  vec_t  comb_sb[$];
  flag_t flag_sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic s, input logic [7:0] a, input logic [7:0] b, input logic en);
    sel     = s;
    ac      = a;
    ar      = b;
    flag_en = en;
  endtask

  vec_t  vecs[10];
  vec_t  e;
  flag_t f;

  initial begin
    vecs[0] = '{1'b0, 8'd20,  8'd30,  8'd50,  1'b0, 1'b0};
    vecs[1] = '{1'b1, 8'd20,  8'd30,  8'd20,  1'b0, 1'b0};
    vecs[2] = '{1'b0, 8'hFF,  8'h01,  8'h00,  1'b1, 1'b1};
    vecs[3] = '{1'b1, 8'hF0,  8'h0F,  8'h00,  1'b0, 1'b1};
    vecs[4] = '{1'b0, 8'h80,  8'h80,  8'h00,  1'b1, 1'b1};
    vecs[5] = '{1'b1, 8'hFF,  8'hFF,  8'hFF,  1'b0, 1'b0};
    vecs[6] = '{1'b0, 8'hFF,  8'hFF,  8'hFE,  1'b1, 1'b0};
    vecs[7] = '{1'b0, 8'h00,  8'h00,  8'h00,  1'b0, 1'b1};
    vecs[8] = '{1'b1, 8'hAA,  8'h55,  8'h00,  1'b0, 1'b1};
    vecs[9] = '{1'b0, 8'h7F,  8'h01,  8'h80,  1'b0, 1'b0};

    // Reset: hold inputs that would set both flags if reset were ignored
    rst_n = 1'b1;
    drive(1'b0, 8'hFF, 8'h01, 1'b1);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_c_flag", {31'b0, c_flag}, 32'd0);
    chk("reset_z_flag", {31'b0, z_flag}, 32'd0);
    chk("reset_q_live", {24'b0, q}, 32'h00);
    chk("reset_cout_live", {31'b0, cout}, 32'd1);
    @(negedge clk);
    drive(1'b0, 8'd0, 8'd1, 1'b0);
    rst_n = 1'b1;

    // Table: each vector checked combinationally, then captured into flags
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(vecs[i].sel, vecs[i].ac, vecs[i].ar, 1'b1);
      comb_sb.push_back(vecs[i]);
      flag_sb.push_back('{vecs[i].cout, vecs[i].zero});
      #2;
      if (comb_sb.size() == 0) begin
        chk("comb_sb_empty", 32'd0, 32'd1);
      end else begin
        e = comb_sb.pop_front();
        chk($sformatf("v%0d_q", i), {24'b0, q}, {24'b0, e.q});
        chk($sformatf("v%0d_cout", i), {31'b0, cout}, {31'b0, e.cout});
        chk($sformatf("v%0d_zero", i), {31'b0, zero}, {31'b0, e.zero});
      end
      @(posedge clk);
      #1;
      if (flag_sb.size() == 0) begin
        chk("flag_sb_empty", 32'd0, 32'd1);
      end else begin
        f = flag_sb.pop_front();
        chk($sformatf("v%0d_C_flag", i), {31'b0, c_flag}, {31'b0, f.c});
        chk($sformatf("v%0d_Z_flag", i), {31'b0, z_flag}, {31'b0, f.z});
      end
    end

    // Flag hold: capture 1/1, then disable capture and change operands
    @(negedge clk);
    drive(1'b0, 8'hFF, 8'h01, 1'b1);
    @(posedge clk);
    #1;
    chk("hold_setup_C", {31'b0, c_flag}, 32'd1);
    chk("hold_setup_Z", {31'b0, z_flag}, 32'd1);
    @(negedge clk);
    drive(1'b0, 8'd20, 8'd30, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("hold%0d_C", k), {31'b0, c_flag}, 32'd1);
      chk($sformatf("hold%0d_Z", k), {31'b0, z_flag}, 32'd1);
    end
    chk("hold_q", {24'b0, q}, 32'd50);

    // Asynchronous reset between edges: flags clear immediately, q unaffected
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_C", {31'b0, c_flag}, 32'd0);
    chk("async_rst_Z", {31'b0, z_flag}, 32'd0);
    chk("async_rst_q", {24'b0, q}, 32'd50);
    chk("async_rst_zero", {31'b0, zero}, 32'd0);

    // Release: no capture while flag_en is low, then first capture after release
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 8'hFF, 8'h01, 1'b0);
    @(posedge clk);
    #1;
    chk("post_rst_noen_C", {31'b0, c_flag}, 32'd0);
    chk("post_rst_noen_Z", {31'b0, z_flag}, 32'd0);
    @(negedge clk);
    flag_en = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_cap_C", {31'b0, c_flag}, 32'd1);
    chk("post_rst_cap_Z", {31'b0, z_flag}, 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/alu.md
# alu

Combinational 8-bit arithmetic/logic unit of the Simple CPU datapath. It produces ADD or AND of the accumulator (AC) and the address/operand register (AR) on `q`, selected by `ALUSEL`. It also keeps a small clocked status register (zero and carry flags) that the control unit samples for conditional operations. It sits between the AC/AR registers and the AC write-back mux.

## Interface
Parameters:
- `N`, default 8: datapath width in bits.

Ports:
- `clk`, input, 1 bit: single system clock; the flag register updates on its rising edge.
- `rst_n`, input, 1 bit: asynchronous, active-low reset; clears the flag register.
- `flag_en`, input, 1 bit: when 1, the flag register captures the current result flags at the next rising `clk`.
- `ALUSEL`, input, 1 bit: operation select; 0 = ADD, 1 = AND.
- `AC`, input, N bits: accumulator operand.
- `AR`, input, N bits: second operand.
- `q`, output, N bits: combinational result.
- `cout`, output, 1 bit: combinational carry-out of the ADD; 0 when `ALUSEL`=1.
- `zero`, output, 1 bit: combinational, 1 when `q` == 0.
- `C_flag`, output, 1 bit: registered carry flag.
- `Z_flag`, output, 1 bit: registered zero flag.

## Operation
- `ALUSEL`=0 (ADD): {`cout`, `q`} = AC + AR as an unsigned (N+1)-bit sum; `q` is the sum mod 2^N. No signed overflow output.
- `ALUSEL`=1 (AND): `q` = AC & AR, bitwise; `cout` = 0.
- `zero` = (`q` == 0), evaluated for both operations.
- `ALUSEL` is 1 bit, so no illegal encodings exist. X on `ALUSEL` may propagate X to the outputs.
- Flag register:
  - On rising `clk` with `flag_en`=1: `C_flag` <= `cout`, `Z_flag` <= `zero`.
  - With `flag_en`=0: both flags hold their value.
- Reset: `rst_n`=0 immediately forces `C_flag`=0 and `Z_flag`=0, regardless of `clk`. Reset has no effect on the combinational outputs `q`, `cout` and `zero`.

## Timing
- `q`, `cout`, `zero`: purely combinational; zero cycles of latency. They must settle within one clock period, and within 10 ns of any input change in simulation.
- `C_flag`, `Z_flag`:
  - One-cycle latency: they reflect the inputs present at the `clk` edge where `flag_en`=1.
  - Reset value is 0.
  - Deasserting `rst_n` is synchronous-safe: the first capture occurs on the first rising edge after release with `flag_en`=1.
- Reset asserted mid-operation: the flags clear at once; `q` keeps tracking the inputs.
- `flag_en` and an operand change in the same cycle: the flags take the values present at the edge.

## Test plan
- ADD: `ALUSEL`=0, AC=20, AR=30 -> `q`=50, `cout`=0, `zero`=0 within 10 ns.
- AND: `ALUSEL`=1, AC=20, AR=30 -> `q`=8'b00010100 (20), `cout`=0, `zero`=0.
- ADD wrap-around: AC=8'hFF, AR=8'h01, `ALUSEL`=0 -> `q`=0, `cout`=1, `zero`=1. With `flag_en`=1 and one `clk` edge -> `C_flag`=1, `Z_flag`=1.
- AND to zero: AC=8'hF0, AR=8'h0F, `ALUSEL`=1 -> `q`=0, `zero`=1, `cout`=0.
- Flag hold: after the flags capture 1/1, set `flag_en`=0 and change the inputs to 20+30 -> the flags stay 1/1 across 3 clock edges.
- Asynchronous reset: with flags at 1/1, pull `rst_n` low between clock edges -> both flags read 0 before the next edge, while `q` still shows the current result.
